// File: rtl/regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard; x0 reads zero.
// Latency: reads combinational, writes/busy updates visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none, every port is accepted each cycle; consumers stall on rd_busy.
`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif

module regfile_sb #(
  parameter  int RegisterCount = `REGISTER_COUNT,
  parameter  int DataWidth     = 32,
  parameter  int ReadPorts     = 2,
  parameter  int WritePorts    = 2,
  parameter  int EnableReset   = 1,
  localparam int AW            = $clog2(RegisterCount)
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic [ReadPorts*AW-1:0]         rd_reg,
  output logic [ReadPorts*DataWidth-1:0]  rd_data,
  output logic [ReadPorts-1:0]            rd_busy,
  input  logic [WritePorts-1:0]           wr_en,
  input  logic [WritePorts*AW-1:0]        wr_reg,
  input  logic [WritePorts*DataWidth-1:0] wr_data,
  input  logic                            issue_en,
  input  logic [AW-1:0]                   issue_reg,
  input  logic                            flush,
  output logic [AW:0]                     busy_count
);

  localparam logic [AW:0] RC = (AW+1)'(RegisterCount);

  if (ReadPorts < 1 || ReadPorts > 4) begin : g_bad_rp
    $error("regfile_sb: ReadPorts must be 1..4");
  end
  if (WritePorts < 1 || WritePorts > 3) begin : g_bad_wp
    $error("regfile_sb: WritePorts must be 1..3");
  end

  logic [DataWidth-1:0]     mem [RegisterCount];
  logic [RegisterCount-1:0] busy_q;
  logic [RegisterCount-1:0] busy_nxt;

  // x0 and indices past the end of a non-power-of-two file are not real registers
  function automatic logic valid_idx(input logic [AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < RC);
  endfunction

  function automatic logic [AW:0] popcount(input logic [RegisterCount-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int r = 0; r < RegisterCount; r++) c = c + {{AW{1'b0}}, v[r]};
    return c;
  endfunction

  // Writebacks retire producers; a flush wipes everything and swallows the issue,
  // otherwise a new issue overrides a same-cycle writeback clear.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < WritePorts; w++) begin
      if (wr_en[w] && valid_idx(wr_reg[w*AW +: AW])) busy_nxt[wr_reg[w*AW +: AW]] = 1'b0;
    end
    if (flush) busy_nxt = '0;
    else if (issue_en && valid_idx(issue_reg)) busy_nxt[issue_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      busy_q     <= '0;
      busy_count <= '0;
      if (EnableReset != 0) begin
        for (int r = 0; r < RegisterCount; r++) mem[r] <= '0;
      end
    end else begin
      busy_q     <= busy_nxt;
      busy_count <= popcount(busy_nxt);
      // ascending port order so the highest-indexed port's assignment lands last
      for (int w = 0; w < WritePorts; w++) begin
        if (wr_en[w] && valid_idx(wr_reg[w*AW +: AW]))
          mem[wr_reg[w*AW +: AW]] <= wr_data[w*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] idx;
    idx     = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < ReadPorts; i++) begin
      idx = rd_reg[i*AW +: AW];
      if (valid_idx(idx)) begin
        rd_data[i*DataWidth +: DataWidth] = mem[idx];
        rd_busy[i]                        = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < WritePorts; w++) begin
          if (wr_en[w] && wr_reg[w*AW +: AW] == idx) begin
            rd_data[i*DataWidth +: DataWidth] = wr_data[w*DataWidth +: DataWidth];
            rd_busy[i]                        = issue_en && (issue_reg == idx);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb using a 24-entry file so out-of-range indices exist.
module tb_regfile_sb;
  localparam int NR = 24;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            res;
  logic [AW-1:0]   rr0, rr1;
  logic [2*AW-1:0] rd_reg;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [AW-1:0]   wr0, wr1;
  logic [DW-1:0]   wd0, wd1;
  logic [2*AW-1:0] wr_reg;
  logic [2*DW-1:0] wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_reg;
  logic            flush;
  logic [AW:0]     busy_count;

  int n_cmp = 0;
  int n_bad = 0;

  assign rd_reg  = {rr1, rr0};
  assign wr_reg  = {wr1, wr0};
  assign wr_data = {wd1, wd0};

  always #50 clk = ~clk;

  regfile_sb #(.RegisterCount(NR), .DataWidth(DW), .ReadPorts(2), .WritePorts(2), .EnableReset(1)) dut (
    .clk(clk), .res(res), .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .issue_en(issue_en),
    .issue_reg(issue_reg), .flush(flush), .busy_count(busy_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    res      = 1'b0;
    wr_en    = 2'b00;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wr_a(input int r, input logic [31:0] d);
    wr_en[0] = 1'b1; wr0 = AW'(r); wd0 = d;
  endtask

  task automatic wr_b(input int r, input logic [31:0] d);
    wr_en[1] = 1'b1; wr1 = AW'(r); wd1 = d;
  endtask

  task automatic iss(input int r);
    issue_en = 1'b1; issue_reg = AW'(r);
  endtask

  task automatic peek(input string tag, input int r, input logic [31:0] ed, input logic eb);
    rr0 = AW'(r);
    #1;
    check({tag, ".data"}, {32'h0, rd_data[DW-1:0]}, {32'h0, ed});
    check({tag, ".busy"}, {63'h0, rd_busy[0]}, {63'h0, eb});
  endtask

  task automatic count(input string tag, input int e);
    check(tag, {58'h0, busy_count}, 64'(e));
  endtask

  initial begin
    res = 1'b1; rr0 = '0; rr1 = '0; wr_en = 2'b00; wr0 = '0; wr1 = '0;
    wd0 = '0; wd1 = '0; issue_en = 1'b0; issue_reg = '0; flush = 1'b0;
    step();
    res = 1'b1;
    step();
    count("rst.count", 0);

    // populate x1..x10 with random data and mark x11..x20 busy
    for (int i = 1; i <= 10; i++) begin
      wr_a(i, $urandom);
      iss(i + 10);
      step();
    end
    count("fill.count", 10);
    peek("fill.x11", 11, 32'h0, 1'b1);

    // reset beats concurrent writes and an issue
    res = 1'b1;
    wr_a(5, 32'h1234);
    wr_b(12, 32'h5678);
    iss(7);
    step();
    count("res.count", 0);
    peek("res.x1", 1, 32'h0, 1'b0);
    peek("res.x5", 5, 32'h0, 1'b0);
    peek("res.x12", 12, 32'h0, 1'b0);
    peek("res.x7", 7, 32'h0, 1'b0);
    peek("res.x11", 11, 32'h0, 1'b0);

    wr_a(5, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
    peek("raw.x5", 5, 32'hDEADBEEF, 1'b0);
`else
    peek("raw.x5", 5, 32'h0, 1'b0);
`endif
    step();
    peek("wr.x5", 5, 32'hDEADBEEF, 1'b0);
    wr_a(0, 32'h1);
    step();
    peek("wr.x0", 0, 32'h0, 1'b0);

    wr_a(7, 32'h11);
    wr_b(7, 32'h22);
    step();
    peek("conflict.x7", 7, 32'h22, 1'b0);
    rr1 = AW'(7);
    #1;
    check("conflict.rd1", {32'h0, rd_data[2*DW-1:DW]}, 64'h22);

    iss(3);
    step();
    peek("issue.x3", 3, 32'h0, 1'b1);
    count("issue.count", 1);
    wr_a(3, 32'h44);
    step();
    peek("wb.x3", 3, 32'h44, 1'b0);
    count("wb.count", 0);
    iss(3);
    wr_b(3, 32'h99);
    step();
    peek("iss_wb.x3", 3, 32'h99, 1'b1);
    count("iss_wb.count", 1);
    iss(3);
    step();
    count("reissue.count", 1);

    iss(1); step();
    iss(2); step();
    iss(4); step();
    count("multi.count", 4);
    flush = 1'b1;
    iss(6);
    wr_a(12, 32'h77);
    step();
    count("flush.count", 0);
    peek("flush.x6", 6, 32'h0, 1'b0);
    peek("flush.x12", 12, 32'h77, 1'b0);
    peek("flush.x3", 3, 32'h99, 1'b0);

    wr_a(9, 32'h11); step();
    iss(9); step();
    count("x9.count", 1);
    wr_a(9, 32'h55);
`ifdef REGFILE_BYPASS_EN
    peek("byp.x9", 9, 32'h55, 1'b0);
`else
    peek("byp.x9", 9, 32'h11, 1'b1);
`endif
    step();
    peek("byp_next.x9", 9, 32'h55, 1'b0);
    count("byp_next.count", 0);
    wr_a(9, 32'h66);
    iss(9);
`ifdef REGFILE_BYPASS_EN
    peek("byp_iss.x9", 9, 32'h66, 1'b1);
`else
    peek("byp_iss.x9", 9, 32'h55, 1'b0);
`endif
    step();
    peek("byp_iss_next.x9", 9, 32'h66, 1'b1);
    wr_a(9, 32'h66); step();

    // index 30 does not exist in a 24-entry file
    wr_a(30, 32'hABC);
    iss(30);
    step();
    count("oor.count", 0);
    peek("oor.x30", 30, 32'h0, 1'b0);
    wr_a(23, 32'h5A); step();
    peek("top.x23", 23, 32'h5A, 1'b0);

    iss(0); step();
    count("x0.count", 0);
    peek("x0.busy", 0, 32'h0, 1'b0);

    iss(10); step();
    iss(11); step();
    count("dual.count_set", 2);
    wr_a(10, 32'hA);
    wr_b(11, 32'hB);
    step();
    count("dual.count_clr", 0);
    peek("dual.x10", 10, 32'hA, 1'b0);
    peek("dual.x11", 11, 32'hB, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
